// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: 8-requester round-robin arbiter with a hold-limit counter.
//
// A requester keeps the grant while it holds its request. If another
// requester is pending once the owner has held for MAX_HOLD cycles, the
// grant is rotated to the next requester with no idle cycle in between.
//
// Ports:
//   clk          - rising-edge clock
//   reset        - synchronous, active-high reset
//   req[7:0]     - level-sensitive request vector, bit i = requester i
//   grant[7:0]   - registered one-hot grant, zero when idle
//   grant_idx    - registered binary index of the grant bit, 0 when idle
//   grant_valid  - high whenever grant is nonzero
//   hold_expired - registered one-cycle pulse when a forced rotation lands
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       hold_expired
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);

    state_t           state, state_nx;
    logic [2:0]       ptr, ptr_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [7:0]       grant_nx;
    logic [2:0]       idx_nx;
    logic             he_nx;

    logic [7:0]       others;
    logic             owner_req;
    logic [7:0]       cand;
    logic [3:0]       pick;

    // Returns {found, index} of the first set bit of mask, scanning
    // base, base+1, ... base+7 modulo 8. The loop runs from the farthest
    // offset down so the nearest set bit is the last one written.
    function automatic logic [3:0] rr_pick(input logic [7:0] mask, input logic [2:0] base);
        logic [3:0] res;
        logic [2:0] j;
        res = '0;
        for (int k = 7; k >= 0; k--) begin
            j = base + 3'(k);
            if (mask[j]) res = {1'b1, j};
        end
        return res;
    endfunction

    // Everyone except the current owner; in IDLE grant is zero so this is req.
    assign others    = req & ~grant;
    assign owner_req = |(req & grant);
    assign cand      = (state == IDLE) ? req : others;
    assign pick      = rr_pick(cand, ptr);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            cnt          <= '0;
            grant        <= '0;
            grant_idx    <= '0;
            hold_expired <= 1'b0;
        end else begin
            state        <= state_nx;
            ptr          <= ptr_nx;
            cnt          <= cnt_nx;
            grant        <= grant_nx;
            grant_idx    <= idx_nx;
            hold_expired <= he_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        grant_nx = grant;
        idx_nx   = grant_idx;
        he_nx    = 1'b0;

        unique case (state)
            IDLE: begin
                if (pick[3]) begin
                    state_nx = GRANT;
                    grant_nx = 8'(1) << pick[2:0];
                    idx_nx   = pick[2:0];
                    ptr_nx   = pick[2:0] + 3'd1;
                    cnt_nx   = CNT_W'(1);
                end
            end
            GRANT: begin
                if (owner_req) begin
                    if (others == 8'h00) begin
                        // Sole requester: count saturates, never forced off.
                        if (cnt < MAX_CNT) cnt_nx = cnt + CNT_W'(1);
                    end else if (cnt < MAX_CNT) begin
                        cnt_nx = cnt + CNT_W'(1);
                    end else begin
                        // Hold limit reached with competition: rotate now.
                        grant_nx = 8'(1) << pick[2:0];
                        idx_nx   = pick[2:0];
                        ptr_nx   = pick[2:0] + 3'd1;
                        cnt_nx   = CNT_W'(1);
                        he_nx    = 1'b1;
                    end
                end else if (pick[3]) begin
                    // Owner released while others wait: hand over directly.
                    grant_nx = 8'(1) << pick[2:0];
                    idx_nx   = pick[2:0];
                    ptr_nx   = pick[2:0] + 3'd1;
                    cnt_nx   = CNT_W'(1);
                end else begin
                    state_nx = IDLE;
                    grant_nx = '0;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign grant_valid = |grant;

endmodule

// File: tb/tb_rr_arbiter_8.sv
module tb_rr_arbiter_8;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       hold_expired;

    rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .grant        (grant),
        .grant_idx    (grant_idx),
        .grant_valid  (grant_valid),
        .hold_expired (hold_expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] g;
        logic [2:0] idx;
        logic       v;
        logic       he;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;

    // Reference model state
    int m_idx   = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;
    bit m_valid = 0;
    bit m_he    = 0;

    function automatic int first_from(input logic [7:0] mask, input int base);
        for (int k = 0; k < 8; k++) begin
            int j;
            j = (base + k) % 8;
            if (mask[j]) return j;
        end
        return -1;
    endfunction

    task automatic give(input int w);
        m_valid = 1;
        m_idx   = w;
        m_cnt   = 1;
        m_ptr   = (w + 1) % 8;
    endtask

    task automatic model_step(input logic rst_v, input logic [7:0] r);
        logic [7:0] mask;
        exp_t e;
        m_he = 0;
        if (rst_v) begin
            m_valid = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
        end else if (!m_valid) begin
            if (r != 8'h00) give(first_from(r, m_ptr));
        end else begin
            mask = r;
            mask[m_idx] = 1'b0;
            if (r[m_idx]) begin
                if (m_cnt < MAX_HOLD) m_cnt++;
                else if (mask != 8'h00) begin
                    give(first_from(mask, m_ptr));
                    m_he = 1;
                end
            end else if (mask != 8'h00) begin
                give(first_from(mask, m_ptr));
            end else begin
                m_valid = 0; m_idx = 0; m_cnt = 0;
            end
        end
        e.g   = m_valid ? (8'h01 << m_idx) : 8'h00;
        e.idx = 3'(m_idx);
        e.v   = m_valid;
        e.he  = m_he;
        q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Drive one cycle, then compare DUT against the scoreboard entry.
    task automatic cyc(input logic rst_v, input logic [7:0] r);
        exp_t e;
        reset = rst_v;
        req   = r;
        model_step(rst_v, r);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("sb_empty", 8'd1, 8'd0);
        end else begin
            e = q.pop_front();
            chk("sb_grant", grant, e.g);
            chk("sb_idx", {5'd0, grant_idx}, {5'd0, e.idx});
            chk("sb_valid", {7'd0, grant_valid}, {7'd0, e.v});
            chk("sb_hold_expired", {7'd0, hold_expired}, {7'd0, e.he});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        int cur;
        int he_seen;
        reset = 1'b1;
        req   = 8'h00;
        @(negedge clk);

        // Reset then idle
        cyc(1, 8'h00);
        cyc(1, 8'h00);
        chk("rst_grant", grant, 8'h00);
        chk("rst_idx", {5'd0, grant_idx}, 8'h00);
        chk("rst_valid", {7'd0, grant_valid}, 8'h00);
        cyc(0, 8'h00);
        chk("idle_grant", grant, 8'h00);

        // Single request on bit 2
        cyc(0, 8'b0000_0100);
        chk("single_grant", grant, 8'b0000_0100);
        chk("single_idx", {5'd0, grant_idx}, 8'd2);
        cyc(0, 8'b0000_0100);
        cyc(0, 8'b0000_0100);
        chk("single_hold", grant, 8'b0000_0100);
        cyc(0, 8'h00);
        chk("single_release", grant, 8'h00);
        chk("single_release_v", {7'd0, grant_valid}, 8'h00);

        // Round-robin fairness from ptr=0, with 7 -> 0 wrap
        cyc(1, 8'h00);
        cyc(0, 8'hFF);
        chk("rr_first", {5'd0, grant_idx}, 8'd0);
        cur = 0;
        for (int i = 0; i < 8; i++) begin
            r = 8'hFF;
            r[cur] = 1'b0;
            cyc(0, r);
            cur = (cur + 1) % 8;
            chk("rr_idx", {5'd0, grant_idx}, 8'(cur));
            chk("rr_nobubble", {7'd0, grant_valid}, 8'd1);
        end
        cyc(0, 8'h00);
        chk("rr_idle", grant, 8'h00);

        // Hold limit with competitor on bit 5
        cyc(1, 8'h00);
        cyc(0, 8'b0000_0010);
        cyc(0, 8'b0000_0010);
        cyc(0, 8'b0010_0010);
        chk("hold_keep1", {5'd0, grant_idx}, 8'd1);
        cyc(0, 8'b0010_0010);
        chk("hold_keep2", {5'd0, grant_idx}, 8'd1);
        chk("hold_no_he", {7'd0, hold_expired}, 8'd0);
        cyc(0, 8'b0010_0010);
        chk("hold_forced_idx", {5'd0, grant_idx}, 8'd5);
        chk("hold_forced_he", {7'd0, hold_expired}, 8'd1);
        cyc(0, 8'b0010_0010);
        chk("hold_he_pulse", {7'd0, hold_expired}, 8'd0);
        chk("hold_owner5", {5'd0, grant_idx}, 8'd5);
        cyc(0, 8'b0000_0010);
        chk("hold_regrant1", {5'd0, grant_idx}, 8'd1);

        // Sole requester 6 is never forced off
        cyc(0, 8'h00);
        he_seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 8'b0100_0000);
            chk("sole_idx", {5'd0, grant_idx}, 8'd6);
            if (hold_expired !== 1'b0) he_seen++;
        end
        chk("sole_no_he", 8'(he_seen), 8'd0);
        cyc(0, 8'h00);

        // Reset mid-grant
        cyc(0, 8'b0000_1000);
        chk("mid_owner3", {5'd0, grant_idx}, 8'd3);
        cyc(1, 8'hFF);
        chk("mid_rst_grant", grant, 8'h00);
        chk("mid_rst_valid", {7'd0, grant_valid}, 8'd0);
        cyc(0, 8'hFF);
        chk("mid_ptr0", {5'd0, grant_idx}, 8'd0);
        chk("mid_grant0", grant, 8'h01);
        cyc(0, 8'h00);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- 8-requester round-robin arbiter that shares one downstream resource among eight sources.
- Produces a registered one-hot grant plus its 3-bit encoded index, matching the 8-to-3 encoding used elsewhere in the design.
- A grant is held while the owner keeps its request asserted.
- A hold-limit counter forces rotation so no requester can starve the others.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one owner may hold the grant while another requester is pending; legal range 1..255.
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- req, input, 8: request vector; bit i is requester i; level-sensitive; held until the requester is done.
- grant, output, 8: one-hot grant, registered; all zeros when idle.
- grant_idx, output, 3: binary index of the set grant bit, registered; 0 when idle.
- grant_valid, output, 1: high when grant is nonzero.
- hold_expired, output, 1: one-cycle pulse, registered; high in the cycle where a forced rotation takes effect.

Behaviour:
- Reset (reset=1 at a clk edge):
  - grant=0, grant_idx=0, grant_valid=0, hold_expired=0.
  - Priority pointer ptr=0, hold count cnt=0, state=IDLE.
  - Reset wins over any simultaneous req activity.
  - Reset asserted mid-grant drops the grant at that same edge.
- Priority search:
  - Winner = first set bit of the candidate mask, scanning ptr, ptr+1, ... ptr+7 modulo 8 (index 7 wraps to 0).
- State IDLE (grant=0):
  - req nonzero at edge n: grant/grant_idx/grant_valid show the winner after edge n (1-cycle latency); cnt=1; go to GRANT.
  - req all zeros: stay IDLE.
- State GRANT, owner o:
  - req[o]=1 and no other req bit set: keep grant; cnt saturates at MAX_HOLD.
  - req[o]=1, another bit set, cnt<MAX_HOLD: keep grant; cnt increments.
  - req[o]=1, another bit set, cnt==MAX_HOLD: forced rotation. Candidate mask = req with bit o cleared. New winner granted at this edge with no idle bubble; hold_expired=1 for one cycle; cnt=1.
  - req[o]=0 (release), another bit set: switch directly to the new winner at this edge, no bubble; cnt=1.
  - req[o]=0, no other bit set: grant=0 at this edge; go to IDLE.
- Pointer update:
  - On every new grant to winner w, ptr becomes (w+1) mod 8.
  - ptr is unchanged while a grant is held or while idle.
- Invariants:
  - grant is always zero or one-hot.
  - grant_idx always equals the encoding of grant.
  - grant_valid equals the OR-reduction of grant.
  - A requester that drops req before being granted is never granted.
  - Only the current owner's req bit is examined for hold; other bits may toggle freely.
- Arithmetic:
  - ptr is 3 bits and wraps naturally.
  - cnt is CNT_W bits and never exceeds MAX_HOLD.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, req=8'h00 → grant=0, grant_idx=0, grant_valid=0, hold_expired=0 throughout.
- Single request: req=8'b0000_0100 from cycle 3 → grant=8'b0000_0100, grant_idx=3'd2 after the next edge; held while req persists; req→0 gives grant=0 one edge later.
- Round-robin fairness: req=8'hFF held, owners drop and re-raise req for one cycle each → grants in order idx 0,1,2,...,7,0; wrap from 7 to 0 confirmed with no bubble between owners.
- Hold limit: MAX_HOLD=4; req[1] held continuously, req[5] raised at cycle 10 → idx 1 keeps the grant until cnt reaches 4; next edge gives grant_idx=5 with hold_expired=1 for exactly one cycle; idx 1 is re-granted once 5 releases.
- Sole requester never forced: MAX_HOLD=4, only req[6] held for 20 cycles → grant_idx=6 continuously, hold_expired never asserts.
- Reset mid-grant: owner idx 3 granted, reset pulsed for 1 cycle with req=8'hFF → grant=0 in the reset cycle; the next grant goes to idx 0 (ptr reset to 0).
